// File: rtl/alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer
//   Initiator side of the ALU operand/opcode interface. Operand A, operand B
//   and the opcode arrive one after another on a shared WIDTH-bit bus, one
//   word per din_valid strobe. Once all three are loaded the combinational
//   ALU is given SETTLE cycles, then its output is captured into result.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous active-high reset
//   din          in   WIDTH  shared data word: A, then B, then SEL
//   din_valid    in   1      one-cycle strobe qualifying din
//   alu_out      in   WIDTH  combinational result from the ALU
//   alu_a        out  WIDTH  registered operand A to the ALU
//   alu_b        out  WIDTH  registered operand B to the ALU
//   alu_sel      out  SEL_W  registered opcode to the ALU
//   result       out  WIDTH  captured ALU result
//   result_valid out  1      high while result holds a completed operation
//   overrun      out  1      sticky: din_valid arrived while executing
//   state        out  3      current FSM state (for LEDs)
// ---------------------------------------------------------------------------
module alu_operand_sequencer #(
    parameter int WIDTH  = 6,
    parameter int SEL_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             overrun,
    output logic [2:0]       state
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_SEL  = 3'd2,
        S_EXEC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] alu_a_reg, alu_a_next;
    logic [WIDTH-1:0] alu_b_reg, alu_b_next;
    logic [SEL_W-1:0] alu_sel_reg, alu_sel_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             result_valid_reg, result_valid_next;
    logic             overrun_reg, overrun_next;
    logic [CW-1:0]    cnt_reg, cnt_next;

    always_comb begin
        state_next        = state_reg;
        alu_a_next        = alu_a_reg;
        alu_b_next        = alu_b_reg;
        alu_sel_next      = alu_sel_reg;
        result_next       = result_reg;
        result_valid_next = result_valid_reg;
        overrun_next      = overrun_reg;
        cnt_next          = cnt_reg;

        case (state_reg)
            S_A: begin
                if (din_valid) begin
                    alu_a_next = din;
                    state_next = S_B;
                end
            end
            S_B: begin
                if (din_valid) begin
                    alu_b_next = din;
                    state_next = S_SEL;
                end
            end
            S_SEL: begin
                if (din_valid) begin
                    // Only the low SEL_W bits carry the opcode.
                    alu_sel_next = din[SEL_W-1:0];
                    cnt_next     = '0;
                    state_next   = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_next = cnt_reg + 1'b1;
                // Strobes while the ALU settles are dropped but remembered.
                if (din_valid) begin
                    overrun_next = 1'b1;
                end
                if (cnt_reg == CNT_LAST) begin
                    result_next       = alu_out;
                    result_valid_next = 1'b1;
                    state_next        = S_DONE;
                end
            end
            S_DONE: begin
                // A new A word starts the next operation immediately; the old
                // result stays visible but is no longer flagged valid.
                if (din_valid) begin
                    alu_a_next        = din;
                    result_valid_next = 1'b0;
                    overrun_next      = 1'b0;
                    state_next        = S_B;
                end
            end
            default: begin
                state_next = S_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= S_A;
            alu_a_reg        <= '0;
            alu_b_reg        <= '0;
            alu_sel_reg      <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
            cnt_reg          <= '0;
        end else begin
            state_reg        <= state_next;
            alu_a_reg        <= alu_a_next;
            alu_b_reg        <= alu_b_next;
            alu_sel_reg      <= alu_sel_next;
            result_reg       <= result_next;
            result_valid_reg <= result_valid_next;
            overrun_reg      <= overrun_next;
            cnt_reg          <= cnt_next;
        end
    end

    assign alu_a        = alu_a_reg;
    assign alu_b        = alu_b_reg;
    assign alu_sel      = alu_sel_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign overrun      = overrun_reg;
    assign state        = state_reg;

endmodule
